// File: rtl/logic_gate_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_gate_pipe
// Brief    : Pipelined WIDTH-bit bitwise gate engine with per-stage
//            valid/ready, equality flag, popcount and saturating transfer count.
// Revision : 1.0 - initial release
// ============================================================================
module logic_gate_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             a,
   input  logic [WIDTH-1:0]             b,
   input  logic [2:0]                   op,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             y,
   output logic                         eq,
   output logic [$clog2(WIDTH+1)-1:0]   ones,
   output logic [CNT_W-1:0]             xfer_cnt
);

   localparam int c_ONES_W = $clog2(WIDTH+1);

   logic [WIDTH-1:0]    w_fn;
   logic                w_eq;
   logic [c_ONES_W-1:0] w_ones;

   logic [STAGES-1:0]   r_valid;
   logic [WIDTH-1:0]    r_y    [STAGES];
   logic [STAGES-1:0]   r_eq;
   logic [c_ONES_W-1:0] r_ones [STAGES];
   logic [CNT_W-1:0]    r_cnt;

   logic [STAGES-1:0]   w_load;
   logic [STAGES-1:0]   w_src_valid;
   logic [WIDTH-1:0]    w_src_y    [STAGES];
   logic [STAGES-1:0]   w_src_eq;
   logic [c_ONES_W-1:0] w_src_ones [STAGES];

   always_comb begin
      w_fn = '0;
      case (op)
         3'b000:  w_fn = a & b;
         3'b001:  w_fn = a | b;
         3'b010:  w_fn = a ^ b;
         3'b011:  w_fn = ~(a ^ b);
         3'b100:  w_fn = ~(a & b);
         3'b101:  w_fn = ~(a | b);
         3'b110:  w_fn = ~a;
         default: w_fn = a;
      endcase
   end

   assign w_eq = &(a ~^ b);

   always_comb begin
      w_ones = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_ones = w_ones + c_ONES_W'(w_fn[i]);
      end
   end

   // A stage can load unless it and every stage downstream of it are full
   // while the consumer stalls; this closed form avoids a ready ripple chain.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      assign w_load[k] = out_ready | ~(&r_valid[STAGES-1:k]);
      if (k == 0) begin : g_first
         assign w_src_valid[k] = in_valid;
         assign w_src_y[k]     = w_fn;
         assign w_src_eq[k]    = w_eq;
         assign w_src_ones[k]  = w_ones;
      end else begin : g_next
         assign w_src_valid[k] = r_valid[k-1];
         assign w_src_y[k]     = r_y[k-1];
         assign w_src_eq[k]    = r_eq[k-1];
         assign w_src_ones[k]  = r_ones[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_eq    <= '0;
         r_cnt   <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_y[k]    <= '0;
            r_ones[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (w_load[k]) begin
               r_valid[k] <= w_src_valid[k];
               // data only moves with a real beat so idle outputs hold last
               if (w_src_valid[k]) begin
                  r_y[k]    <= w_src_y[k];
                  r_eq[k]   <= w_src_eq[k];
                  r_ones[k] <= w_src_ones[k];
               end
            end
         end
         if (r_valid[STAGES-1] && out_ready && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign in_ready  = w_load[0];
   assign out_valid = r_valid[STAGES-1];
   assign y         = r_y[STAGES-1];
   assign eq        = r_eq[STAGES-1];
   assign ones      = r_ones[STAGES-1];
   assign xfer_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_gate_pipe
// Brief    : Scoreboard bench for logic_gate_pipe (directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_logic_gate_pipe;

   localparam int WIDTH  = 8;
   localparam int STAGES = 2;
   localparam int CNT_W  = 16;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic [7:0] y;
      logic       eq;
      logic [3:0] ones;
   } vec_t;

   typedef struct packed {
      vec_t v;
      int   acc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic             r_in_valid, r_out_ready;
   logic [7:0]       r_a, r_b;
   logic [2:0]       r_op;
   logic             w_in_ready, w_out_valid, w_eq;
   logic [7:0]       w_y;
   logic [3:0]       w_ones;
   logic [CNT_W-1:0] w_xfer;

   logic             r_in_valid2, r_out_ready2;
   logic [7:0]       r_a2, r_b2;
   logic [2:0]       r_op2;
   logic             w_in_ready2, w_out_valid2, w_eq2;
   logic [7:0]       w_y2;
   logic [3:0]       w_ones2;
   logic [3:0]       w_xfer2;

   logic_gate_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(r_in_valid), .in_ready(w_in_ready),
      .a(r_a), .b(r_b), .op(r_op),
      .out_valid(w_out_valid), .out_ready(r_out_ready),
      .y(w_y), .eq(w_eq), .ones(w_ones), .xfer_cnt(w_xfer)
   );

   logic_gate_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(4)) u_dut_cnt4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(r_in_valid2), .in_ready(w_in_ready2),
      .a(r_a2), .b(r_b2), .op(r_op2),
      .out_valid(w_out_valid2), .out_ready(r_out_ready2),
      .y(w_y2), .eq(w_eq2), .ones(w_ones2), .xfer_cnt(w_xfer2)
   );

   vec_t vecs [22];
   exp_t q [$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   lat_chk = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic setv(input int i, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [7:0] y,
                       input logic eq, input logic [3:0] ones);
      vecs[i] = '{a: a, b: b, op: op, y: y, eq: eq, ones: ones};
   endtask

   // Monitor: pops on every output transfer, checks hold while stalled.
   always @(negedge clk) begin
      if (rst_n && w_out_valid) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got y=%0h with empty scoreboard", w_y);
         end else if (r_out_ready) begin
            mon_e = q.pop_front();
            chk("y", w_y, mon_e.v.y);
            chk("eq", w_eq, mon_e.v.eq);
            chk("ones", w_ones, mon_e.v.ones);
            if (lat_chk) chk("latency", cyc - mon_e.acc, STAGES);
         end else begin
            chk("hold_y", w_y, q[0].v.y);
            chk("hold_eq", w_eq, q[0].v.eq);
            chk("hold_ones", w_ones, q[0].v.ones);
         end
      end
   end

   // mode 0: out_ready=1; 1: stall cycles 2..5; 2: alternate; 3: out_ready=0
   task automatic stream(input int start, input int n, input int mode);
      int i = 0;
      int c = 0;
      while (i < n && c < 200) begin
         case (mode)
            0:       r_out_ready = 1'b1;
            1:       r_out_ready = !(c >= 2 && c <= 5);
            2:       r_out_ready = (c % 2 == 0);
            default: r_out_ready = 1'b0;
         endcase
         r_in_valid = 1'b1;
         r_a  = vecs[start+i].a;
         r_b  = vecs[start+i].b;
         r_op = vecs[start+i].op;
         @(negedge clk);
         if (mode == 1) chk("in_ready_stall", w_in_ready, (c < 2 || c > 5));
         if (mode == 2) chk("in_ready_alt", w_in_ready, (c < 2 || c % 2 == 0));
         if (w_in_ready) begin
            q.push_back('{v: vecs[start+i], acc: cyc});
            i++;
         end
         @(posedge clk);
         #1;
         c++;
      end
      if (i < n) chk("stream_timeout", i, n);
      r_in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      r_out_ready = 1'b1;
      while (q.size() != 0 && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain", q.size(), 0);
   endtask

   task automatic run_cnt4(input int n);
      int acc = 0;
      int c = 0;
      r_in_valid2 = 1'b1;
      while (acc < n && c < 100) begin
         @(negedge clk);
         if (w_in_ready2) acc++;
         @(posedge clk);
         #1;
         c++;
      end
      r_in_valid2 = 1'b0;
      chk("cnt4_beats", acc, n);
      repeat (5) @(posedge clk);
      #1;
   endtask

   initial begin
      setv(0,  8'hA5, 8'h0F, 3'd0, 8'h05, 1'b0, 4'd2);
      setv(1,  8'hA5, 8'h0F, 3'd1, 8'hAF, 1'b0, 4'd6);
      setv(2,  8'hA5, 8'h0F, 3'd2, 8'hAA, 1'b0, 4'd4);
      setv(3,  8'hA5, 8'h0F, 3'd3, 8'h55, 1'b0, 4'd4);
      setv(4,  8'hA5, 8'h0F, 3'd4, 8'hFA, 1'b0, 4'd6);
      setv(5,  8'hA5, 8'h0F, 3'd5, 8'h50, 1'b0, 4'd2);
      setv(6,  8'hA5, 8'h0F, 3'd6, 8'h5A, 1'b0, 4'd4);
      setv(7,  8'hA5, 8'h0F, 3'd7, 8'hA5, 1'b0, 4'd4);
      setv(8,  8'h3C, 8'h3C, 3'd3, 8'hFF, 1'b1, 4'd8);
      setv(9,  8'h00, 8'h00, 3'd0, 8'h00, 1'b1, 4'd0);
      setv(10, 8'hF0, 8'hCC, 3'd0, 8'hC0, 1'b0, 4'd2);
      setv(11, 8'hF0, 8'hCC, 3'd1, 8'hFC, 1'b0, 4'd6);
      setv(12, 8'hF0, 8'hCC, 3'd2, 8'h3C, 1'b0, 4'd4);
      setv(13, 8'h12, 8'h12, 3'd4, 8'hED, 1'b1, 4'd6);
      setv(14, 8'h81, 8'h00, 3'd5, 8'h7E, 1'b0, 4'd6);
      setv(15, 8'h01, 8'hFF, 3'd6, 8'hFE, 1'b0, 4'd7);
      setv(16, 8'hAA, 8'h55, 3'd0, 8'h00, 1'b0, 4'd0);
      setv(17, 8'hAA, 8'h55, 3'd1, 8'hFF, 1'b0, 4'd8);
      setv(18, 8'hAA, 8'h55, 3'd3, 8'h00, 1'b0, 4'd0);
      setv(19, 8'h80, 8'h11, 3'd7, 8'h80, 1'b0, 4'd1);
      setv(20, 8'h77, 8'h77, 3'd2, 8'h00, 1'b1, 4'd0);
      setv(21, 8'h0F, 8'h0E, 3'd4, 8'hF1, 1'b0, 4'd5);

      rst_n = 1'b0;
      r_in_valid = 1'b0; r_out_ready = 1'b1; r_a = '0; r_b = '0; r_op = '0;
      r_in_valid2 = 1'b0; r_out_ready2 = 1'b1; r_a2 = 8'h01; r_b2 = 8'h02; r_op2 = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", w_out_valid, 1'b0);
      chk("rst_y", w_y, 8'h00);
      chk("rst_eq", w_eq, 1'b0);
      chk("rst_ones", w_ones, 4'd0);
      chk("rst_xfer", w_xfer, 16'd0);
      chk("rst_in_ready", w_in_ready, 1'b1);
      chk("rst_xfer_cnt4", w_xfer2, 4'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // All eight opcodes back-to-back, latency checked.
      lat_chk = 1'b1;
      stream(0, 8, 0);
      drain();
      stream(8, 2, 0);
      drain();
      lat_chk = 1'b0;

      // Fresh count, then stall mid-stream for four cycles.
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      stream(10, 6, 1);
      drain();
      chk("xfer_after_stall", w_xfer, 16'd6);

      stream(16, 6, 2);
      drain();
      chk("xfer_after_alt", w_xfer, 16'd12);

      // Asynchronous reset with two beats in flight.
      stream(10, 2, 3);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", w_out_valid, 1'b0);
      chk("arst_y", w_y, 8'h00);
      chk("arst_eq", w_eq, 1'b0);
      chk("arst_ones", w_ones, 4'd0);
      chk("arst_xfer", w_xfer, 16'd0);
      chk("arst_in_ready", w_in_ready, 1'b1);
      q.delete();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      lat_chk = 1'b1;
      stream(8, 1, 0);
      drain();
      lat_chk = 1'b0;
      chk("xfer_after_arst", w_xfer, 16'd1);

      // Saturating 4-bit counter: 10 then 20 transfers.
      run_cnt4(10);
      chk("cnt4_at_10", w_xfer2, 4'd10);
      run_cnt4(10);
      chk("cnt4_sat", w_xfer2, 4'd15);

      chk("scoreboard_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/logic_gate_pipe.md
Name: logic_gate_pipe

Overview:
Parametrised, pipelined bitwise gate engine that generalises the single-bit gate cells to WIDTH-bit vectors. A runtime opcode selects one of eight functions. Each stage carries a valid/ready handshake, and the block also produces an equality flag, a popcount and a transfer counter. It sits between operand producers and any consumer needing registered logic results with backpressure.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
STAGES, 2, pipeline depth in register stages (>=1); unstalled latency in cycles
CNT_W, 16, width of the saturating transfer counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  function select, sampled with the beat
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result
y  output  WIDTH  bitwise result
eq  output  1  1 when a==b for that beat
ones  output  $clog2(WIDTH+1)  popcount of y
xfer_cnt  output  CNT_W  number of completed output transfers, saturating

Behaviour:
- Reset is asynchronous, active-low: clk and rst_n only; no other clock or reset.
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NAND, 101 NOR, 110 NOT a (b ignored), 111 BUF a (b ignored).
- eq = AND-reduction of (a XNOR b), independent of op.
- ones = count of 1s in y; zero-extended; max value WIDTH.
- Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
- Function evaluation and eq are computed combinationally ahead of stage 1 and registered into stage 1. ones may be computed in stage 1 or a later stage, but all fields of one beat emerge together.
- Stage k register (valid_k, data_k) loads when !valid_k || ready_k. ready_k is out_ready for the last stage and the next stage's load enable otherwise. in_ready equals stage 1 load enable. Bubbles collapse.
- Latency: a beat accepted at edge n appears at out_valid after edge n+STAGES-1. That is, visible in the cycle following STAGES accepting edges when unstalled. Throughput is 1 beat/cycle with out_ready held high.
- Backpressure: while out_valid && !out_ready, y/eq/ones hold stable; no beat is lost, duplicated or reordered. in_ready drops only once every stage is full.
- Simultaneous in/out transfer on a full pipe is allowed; occupancy is unchanged.
- xfer_cnt increments by 1 per output transfer and holds at 2^CNT_W-1.
- Reset values: all valid_k=0, out_valid=0, y=0, eq=0, ones=0, xfer_cnt=0. in_ready=1 after reset.
- Reset asserted mid-operation discards every in-flight beat immediately, regardless of clk.
- Beats are in order. op is per-beat, so mixed opcodes in flight are legal.
- Inputs are ignored when in_valid=0. Output data is don't-care when out_valid=0 but must be deterministic (hold last).

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1: a=8'hA5, b=8'h0F through op 0..7 -> y=05,AF,AA,55,FA,50,5A,A5. ones=2,6,4,4,6,2,4,4. eq=0. Each arrives 2 cycles after its accept.
- a=b=8'h3C, op=011 -> y=8'hFF, ones=8, eq=1. a=b=0, op=000 -> y=0, ones=0, eq=1.
- Stream 6 beats back-to-back while out_ready is held low for 4 cycles mid-stream -> in_ready falls when 2 beats are buffered. Outputs hold stable while stalled. All 6 results arrive in order. xfer_cnt=6.
- Alternate out_ready 1/0 every cycle with continuous in_valid -> 50% throughput, no loss or duplication, results match a scoreboard.
- Drop rst_n asynchronously mid-cycle with 2 beats in flight -> out_valid=0, y=0, xfer_cnt=0 at once. After release, in_ready=1 and the first new beat emerges with correct latency.
- CNT_W=4: perform 20 transfers -> xfer_cnt stops at 15.
